// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO feeding uart_tx via tx_start/tx_data/tx_done
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              tx_en,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              wr_accept;
  logic              pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_en) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (tx_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // A write while full is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    wr_accept = wr_en && !full;
    wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_accept);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(pop);
    count_d   = count_q + (ADDR_W+1)'(wr_accept) - (ADDR_W+1)'(pop);
    ovf_d     = ovf_q;
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule
